// File: rtl/clm_canonical_reducer.sv
// Serial GF(2^8) reducer: folds a redundant (8+d)-bit element modulo the monic
// polynomial {1,P}, one degree per clock, with a one-entry holding register.
module clm_canonical_reducer #(
  parameter int unsigned d = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           drdy_i,
  input  logic [8+d-1:0] din,
  input  logic [7:0]     P,
  output logic [7:0]     dout,
  output logic           drdy_o,
  output logic           busy,
  output logic           overflow
);

  localparam int unsigned W  = 8 + d;
  localparam int unsigned CW = $clog2(d + 1);
  localparam int unsigned KW = $clog2(W);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state;
  logic [W-1:0]   work;
  logic [W-1:0]   hold;
  logic           hold_full;
  logic [CW-1:0]  cnt;

  logic [KW-1:0]  shamt;
  logic [W-1:0]   lead_mask;
  logic [W-1:0]   poly;
  logic [W-1:0]   step;
  logic           last_step;

  // One reduction step: clear coefficient k = 7+d-cnt by subtracting {1,P}*x^(k-8).
  always_comb begin
    shamt     = KW'(d - 1) - KW'(cnt);
    lead_mask = W'(1) << (shamt + KW'(8));
    poly      = W'({1'b1, P}) << shamt;
    step      = (|(work & lead_mask)) ? (work ^ poly) : work;
    last_step = (cnt == CW'(d - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      work      <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      cnt       <= '0;
      dout      <= '0;
      drdy_o    <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      drdy_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (drdy_i) begin
            work  <= din;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (last_step) begin
            dout   <= step[7:0];
            drdy_o <= 1'b1;
            cnt    <= '0;
            // Held result has priority; a same-cycle strobe refills the hold.
            if (hold_full) begin
              work      <= hold;
              hold_full <= drdy_i;
              if (drdy_i) hold <= din;
            end else if (drdy_i) begin
              work <= din;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            work <= step;
            cnt  <= cnt + CW'(1);
            if (drdy_i) begin
              if (!hold_full) begin
                hold      <= din;
                hold_full <= 1'b1;
              end else begin
                overflow <= 1'b1;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clm_canonical_reducer.sv
// Scoreboard bench for clm_canonical_reducer: stimulus pushes expected results,
// a negedge monitor pops and compares whenever drdy_o pulses.
module tb_clm_canonical_reducer;

  localparam int D = 4;
  localparam int W = 8 + D;

  logic         clk;
  logic         rst;
  logic         drdy_i;
  logic [W-1:0] din;
  logic [7:0]   P;
  logic [7:0]   dout;
  logic         drdy_o;
  logic         busy;
  logic         overflow;

  clm_canonical_reducer #(.d(D)) dut (
    .clk(clk), .rst(rst), .drdy_i(drdy_i), .din(din), .P(P),
    .dout(dout), .drdy_o(drdy_o), .busy(busy), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         a;
    int         f;
    logic [7:0] v;
  } job_t;

  job_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         edge_n = 0;
  int         last_f = 0;
  logic       ovf_exp = 1'b0;
  logic [7:0] held = 8'h00;

  // x mod {1,p} as XOR of the residues x^i mod {1,p} for every set coefficient.
  function automatic logic [7:0] ref_mod(input logic [W-1:0] x, input logic [7:0] p);
    logic [7:0] pw;
    logic [7:0] acc;
    pw  = 8'h01;
    acc = 8'h00;
    for (int i = 0; i < W; i++) begin
      if (x[i]) acc = acc ^ pw;
      pw = {pw[6:0], 1'b0} ^ (pw[7] ? p : 8'h00);
    end
    return acc;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", nm, edge_n, act, exp);
    end
  endtask

  // Job-level model: at most two unfinished jobs; a new job finishes d edges after
  // it can start (now, or when the previous job finishes).
  task automatic drive(input logic s, input logic [W-1:0] x, input logic r);
    int pend;
    int f;
    drdy_i = s;
    din    = x;
    rst    = r;
    @(posedge clk);
    edge_n++;
    if (!r) begin
      sb.delete();
      ovf_exp = 1'b0;
      last_f  = 0;
    end else if (s) begin
      pend = 0;
      foreach (sb[i]) if (sb[i].f > edge_n) pend++;
      if (pend >= 2) begin
        ovf_exp = 1'b1;
      end else begin
        f = ((edge_n > last_f) ? edge_n : last_f) + D;
        sb.push_back('{a: edge_n, f: f, v: ref_mod(x, P)});
        last_f = f;
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b1);
  endtask

  always @(negedge clk) begin
    logic exp_busy;
    while (sb.size() > 0 && sb[0].f < edge_n) begin
      chk("missing_pulse", 0, sb[0].v);
      void'(sb.pop_front());
    end
    if (drdy_o) begin
      if (sb.size() == 0 || sb[0].f != edge_n) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        chk("dout_at_pulse", dout, sb[0].v);
        held = sb[0].v;
        void'(sb.pop_front());
      end
    end
    if (!rst) held = 8'h00;
    exp_busy = 1'b0;
    foreach (sb[i]) if (sb[i].a <= edge_n && edge_n < sb[i].f) exp_busy = 1'b1;
    chk("dout_held", dout, held);
    chk("busy", busy, exp_busy);
    chk("overflow", overflow, ovf_exp);
    if (!rst) chk("drdy_o_reset", drdy_o, 0);
  end

  task automatic job(input logic [W-1:0] x, input logic [7:0] want, input string nm);
    drive(1'b1, x, 1'b1);
    idle(D + 3);
    chk(nm, dout, want);
  endtask

  initial begin
    drdy_i = 1'b0;
    din    = '0;
    rst    = 1'b0;
    P      = 8'h1B;
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    idle(2);

    job(12'h100, 8'h1B, "aes_100");
    job(12'h800, 8'hD8, "aes_800");
    job(12'h0A5, 8'hA5, "aes_0a5");
    job(12'hFFF, 8'h66, "aes_fff");
    job(12'h577, 8'h00, "aes_577_cancel");

    drive(1'b1, 12'h800, 1'b1);
    drive(1'b1, 12'h100, 1'b1);
    idle(2 * D + 3);
    chk("b2b_last", dout, 8'h1B);
    chk("b2b_no_ovf", overflow, 0);

    drive(1'b1, 12'h800, 1'b1);
    drive(1'b1, 12'h100, 1'b1);
    drive(1'b1, 12'h0A5, 1'b1);
    idle(2 * D + 3);
    chk("drop_ovf", overflow, 1);
    chk("drop_last", dout, 8'h1B);
    idle(3);
    chk("ovf_sticky", overflow, 1);

    drive(1'b1, 12'h0A5, 1'b1);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);
    chk("rst_dout", dout, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    idle(D + 2);
    job(12'h100, 8'h1B, "after_rst");

    for (int ph = 0; ph < 8; ph++) begin
      P = 8'($urandom);
      for (int c = 0; c < 250; c++) begin
        if ($urandom_range(0, 149) == 0) drive(1'b0, '0, 1'b0);
        else drive($urandom_range(0, 99) < 40, W'($urandom), 1'b1);
      end
      idle(3 * D + 3);
    end

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
